// File: rtl/melody_player.sv
// Fixed 16-beat melody sequencer producing square-wave PCM on both channels.
// The left channel plays at the note pitch and the right channel one octave lower.
module melody_player #(
  parameter int unsigned BEAT_CYCLES = 12_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play,
  input  logic        stop,
  input  logic        vol_up,
  input  logic        vol_down,
  input  logic        mute,
  output logic [15:0] audio_left,
  output logic [15:0] audio_right,
  output logic [3:0]  beat_idx,
  output logic [1:0]  state,
  output logic [2:0]  volume
);

  typedef enum logic [1:0] {
    StStop  = 2'd0,
    StPlay  = 2'd1,
    StPause = 2'd2
  } state_e;

  localparam int unsigned BeatW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BeatW-1:0] BeatLast = BeatW'(BEAT_CYCLES - 1);

  localparam logic [2:0] VolMin   = 3'd1;
  localparam logic [2:0] VolMax   = 3'd5;
  localparam logic [2:0] VolReset = 3'd3;

  state_e           state_q, state_d;
  logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
  logic [3:0]       beat_q, beat_d;
  logic [18:0]      cnt_l_q, cnt_l_d;
  logic [18:0]      cnt_r_q, cnt_r_d;
  logic             phase_l_q, phase_l_d;
  logic             phase_r_q, phase_r_d;
  logic [2:0]       vol_q, vol_d;
  logic             mute_q;
  logic [15:0]      left_q, left_d;
  logic [15:0]      right_q, right_d;

  logic [3:0]       note;
  logic [18:0]      half_l;
  logic [18:0]      half_r;
  logic [15:0]      amp;
  logic             silent;

  function automatic logic [3:0] melody_note(input logic [3:0] idx);
    logic [3:0] n;
    case (idx)
      4'd0:    n = 4'd1;
      4'd1:    n = 4'd1;
      4'd2:    n = 4'd5;
      4'd3:    n = 4'd5;
      4'd4:    n = 4'd6;
      4'd5:    n = 4'd6;
      4'd6:    n = 4'd5;
      4'd7:    n = 4'd0;
      4'd8:    n = 4'd4;
      4'd9:    n = 4'd4;
      4'd10:   n = 4'd3;
      4'd11:   n = 4'd3;
      4'd12:   n = 4'd2;
      4'd13:   n = 4'd2;
      4'd14:   n = 4'd1;
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  // Rests keep a harmless period; their samples are forced to zero anyway.
  function automatic logic [18:0] half_period(input logic [3:0] code);
    logic [18:0] h;
    case (code)
      4'd1:    h = 19'd190839;
      4'd2:    h = 19'd170068;
      4'd3:    h = 19'd151515;
      4'd4:    h = 19'd143266;
      4'd5:    h = 19'd127551;
      4'd6:    h = 19'd113636;
      4'd7:    h = 19'd101214;
      4'd8:    h = 19'd95602;
      default: h = 19'd190839;
    endcase
    return h;
  endfunction

  assign note   = melody_note(beat_q);
  assign half_l = half_period(note);
  assign half_r = {half_l[17:0], 1'b0};

  // Play state machine; stop always dominates play.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = StStop;
    end else if (play) begin
      case (state_q)
        StStop:  state_d = StPlay;
        StPlay:  state_d = StPause;
        StPause: state_d = StPlay;
        default: state_d = StStop;
      endcase
    end
  end

  // Beat and phase sequencing. STOP holds everything rewound, PAUSE holds.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    beat_d     = beat_q;
    cnt_l_d    = cnt_l_q;
    cnt_r_d    = cnt_r_q;
    phase_l_d  = phase_l_q;
    phase_r_d  = phase_r_q;
    if (stop || (state_q == StStop)) begin
      beat_cnt_d = '0;
      beat_d     = 4'd0;
      cnt_l_d    = 19'd0;
      cnt_r_d    = 19'd0;
      phase_l_d  = 1'b1;
      phase_r_d  = 1'b1;
    end else if (state_q == StPlay) begin
      if (beat_cnt_q == BeatLast) begin
        beat_cnt_d = '0;
        beat_d     = beat_q + 4'd1;
        cnt_l_d    = 19'd0;
        cnt_r_d    = 19'd0;
        phase_l_d  = 1'b1;
        phase_r_d  = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + BeatW'(1);
        if (cnt_l_q == (half_l - 19'd1)) begin
          cnt_l_d   = 19'd0;
          phase_l_d = ~phase_l_q;
        end else begin
          cnt_l_d = cnt_l_q + 19'd1;
        end
        if (cnt_r_q == (half_r - 19'd1)) begin
          cnt_r_d   = 19'd0;
          phase_r_d = ~phase_r_q;
        end else begin
          cnt_r_d = cnt_r_q + 19'd1;
        end
      end
    end
  end

  always_comb begin
    vol_d = vol_q;
    if (vol_up && !vol_down && (vol_q != VolMax)) begin
      vol_d = vol_q + 3'd1;
    end else if (vol_down && !vol_up && (vol_q != VolMin)) begin
      vol_d = vol_q - 3'd1;
    end
  end

  // Samples are built from registered state, so they trail control by one cycle.
  assign amp    = {1'b0, vol_q, 12'h000};
  assign silent = (state_q != StPlay) || (note == 4'd0) || mute_q;

  always_comb begin
    left_d  = 16'h0000;
    right_d = 16'h0000;
    if (!silent) begin
      left_d  = phase_l_q ? amp : (~amp + 16'd1);
      right_d = phase_r_q ? amp : (~amp + 16'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StStop;
      beat_cnt_q <= '0;
      beat_q     <= 4'd0;
      cnt_l_q    <= 19'd0;
      cnt_r_q    <= 19'd0;
      phase_l_q  <= 1'b1;
      phase_r_q  <= 1'b1;
      vol_q      <= VolReset;
      mute_q     <= 1'b0;
      left_q     <= 16'h0000;
      right_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      beat_q     <= beat_d;
      cnt_l_q    <= cnt_l_d;
      cnt_r_q    <= cnt_r_d;
      phase_l_q  <= phase_l_d;
      phase_r_q  <= phase_r_d;
      vol_q      <= vol_d;
      mute_q     <= mute;
      left_q     <= left_d;
      right_q    <= right_d;
    end
  end

  assign audio_left  = left_q;
  assign audio_right = right_q;
  assign beat_idx    = beat_q;
  assign state       = state_q;
  assign volume      = vol_q;

endmodule

// File: doc/melody_player.md
# melody_player

Upstream sample source for the I2S speaker path. It sequences a fixed 16-beat melody and produces signed 16-bit square-wave PCM samples at the melody's pitch on the left channel, and one octave lower on the right. It also provides play/pause/stop control and saturating volume control. Its sample outputs drive the speaker controller's 16-bit left/right audio inputs directly.

## Interface
- BEAT_CYCLES, 12_500_000: clk cycles per beat (8 beats/s at 100 MHz); benches may shrink it.
- clk  in  1  system clock, 100 MHz; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- play  in  1  single-cycle pulse: start, pause or resume.
- stop  in  1  single-cycle pulse: stop and rewind.
- vol_up  in  1  single-cycle pulse: volume +1.
- vol_down  in  1  single-cycle pulse: volume −1.
- mute  in  1  level: forces silence; sequencing continues.
- audio_left  out  16  signed PCM sample for the left channel.
- audio_right  out  16  signed PCM sample for the right channel.
- beat_idx  out  4  current melody beat, 0..15.
- state  out  2  play state: 0=STOP, 1=PLAY, 2=PAUSE.
- volume  out  3  volume level, 1..5.

## Operation
- Melody ROM (beat 0..15): 1,1,5,5,6,6,5,0,4,4,3,3,2,2,1,0.
- Note codes: 0 = rest; 1..8 = C4 D4 E4 F4 G4 A4 B4 C5.
- Left half-period (clk cycles) per note code:
  - 1: 190839; 2: 170068; 3: 151515; 4: 143266
  - 5: 127551; 6: 113636; 7: 101214; 8: 95602
- Right half-period is exactly 2× the left value. Phase counters are 19 bits.
- Each channel has a half-period counter and a phase bit.
  - The counter counts 0..H−1. At H−1 the phase toggles and the counter returns to 0.
  - Phase is high after any restart.
- Amplitude A = volume × 16'h1000, giving 0x1000..0x5000.
- Sample = +A when phase is high, −A (two's complement) when phase is low.
- Sample = 16'h0000 when any of these holds: state ≠ PLAY, note is rest, or mute = 1.
- State machine:
  - STOP + play → PLAY.
  - PLAY + play → PAUSE.
  - PAUSE + play → PLAY.
  - stop in any state → STOP.
  - stop and play in the same cycle → stop wins.
- Entering STOP clears beat_idx, the beat counter, both phase counters, and sets both phases high.
- In PLAY:
  - The beat counter increments every cycle.
  - At BEAT_CYCLES−1 the beat counter returns to 0 and beat_idx increments, wrapping 15→0.
  - On that same edge both phase counters clear and both phases go high (note restart).
- In PAUSE, the beat counter, beat_idx, phase counters and phases all hold. Resume continues exactly where playback paused.
- Volume:
  - vol_up saturates at 5; vol_down saturates at 1.
  - vol_up and vol_down in the same cycle → no change.
  - Volume changes are accepted in every state.
- The mute level does not affect the state machine or counters.

## Timing
- Reset values: state=STOP, beat_idx=0, volume=3, audio_left=audio_right=0, all counters 0, phases high.
- All outputs are registered.
- play pulse sampled at edge t → state=PLAY after edge t → first nonzero sample after edge t+1 (one cycle sample latency).
- Samples reflect state, phase, volume and mute from the previous edge. A change in any of these appears on the audio outputs one cycle later.
- After a play pulse, the phase toggles after H cycles of PLAY.
- beat_idx changes exactly BEAT_CYCLES PLAY-cycles after the previous change. Paused cycles are not counted.
- Reset mid-play: all outputs return to reset values immediately (asynchronous), independent of clk.

## Test plan
- Reset, play pulse, BEAT_CYCLES=1_000_000 → audio_left = 16'h3000 from 2 cycles after the pulse. It flips to 16'hD000 after 190839 PLAY cycles. audio_right flips after 381678 cycles.
- Three vol_up pulses, then a simultaneous vol_up+vol_down → volume 3→4→5→5, then unchanged. The high sample reads 16'h5000.
- Five vol_down pulses → volume saturates at 1; the low sample reads 16'hF000.
- BEAT_CYCLES=16, play, run 16×16+1 cycles → beat_idx steps 0..15 then wraps to 0. At beat_idx=7 (rest), both samples = 0.
- play at beat 3, play again (PAUSE) for 1000 cycles, play again → samples 0 during pause; beat_idx and phase resume unchanged.
- Simultaneous stop+play during PLAY → state=STOP, beat_idx=0, samples 0. Assert mute in PLAY → samples 0 next cycle while beat_idx keeps advancing.
